// File: rtl/dmem_responder_if.sv
// Load/store handshake between the datapath memory initiator (master) and the responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding request, response LATENCY edges after accept, held until resp_ready.
// Byte-lane merged stores, sign/zero-extended loads; `define DMEM_STATS_EN adds load/store/error counters.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic            clock,
  input  logic            reset,
  dmem_responder_if.slave bus
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]     stat_loads,
  output logic [31:0]     stat_stores,
  output logic [31:0]     stat_errors
`endif
);

  localparam int          IDXW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH_WORDS) * 64'd8;
  localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  typedef struct packed {
    logic        write;
    logic [63:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] wdata;
  } req_t;

  logic [63:0] r_mem [DEPTH_WORDS];
  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  req_t        r_req;
  logic [63:0] r_rdata;
  logic        r_err;

  logic            w_done;
  logic            w_misalign;
  logic            w_oor;
  logic            w_err;
  logic            w_commit;
  logic [2:0]      w_lane;
  logic [5:0]      w_shamt;
  logic [IDXW-1:0] w_idx;
  logic [7:0]      w_be;
  logic [63:0]     w_old;
  logic [63:0]     w_new;
  logic [63:0]     w_wshift;
  logic [63:0]     w_rshift;
  logic [63:0]     w_load;

  assign w_done   = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_lane   = r_req.addr[2:0];
  assign w_shamt  = {w_lane, 3'b000};
  assign w_idx    = r_req.addr[IDXW+2:3];
  assign w_oor    = r_req.addr >= ADDR_LIMIT;
  assign w_err    = w_misalign | w_oor;
  assign w_commit = w_done && r_req.write && !w_err;
  assign w_old    = r_mem[w_idx];

  // Aligned accesses never straddle a word, so lane masks cannot overflow.
  always_comb begin
    w_misalign = 1'b0;
    w_be       = 8'h00;
    w_load     = 64'd0;
    w_wshift   = r_req.wdata << w_shamt;
    w_rshift   = w_old >> w_shamt;
    case (r_req.size)
      2'd0: begin
        w_be   = 8'h01 << w_lane;
        w_load = r_req.uns ? {56'd0, w_rshift[7:0]} : {{56{w_rshift[7]}}, w_rshift[7:0]};
      end
      2'd1: begin
        w_misalign = w_lane[0];
        w_be       = 8'h03 << w_lane;
        w_load     = r_req.uns ? {48'd0, w_rshift[15:0]} : {{48{w_rshift[15]}}, w_rshift[15:0]};
      end
      2'd2: begin
        w_misalign = |w_lane[1:0];
        w_be       = 8'h0F << w_lane;
        w_load     = r_req.uns ? {32'd0, w_rshift[31:0]} : {{32{w_rshift[31]}}, w_rshift[31:0]};
      end
      default: begin
        w_misalign = |w_lane;
        w_be       = 8'hFF;
        w_load     = w_rshift;
      end
    endcase
    w_new = w_old;
    for (int b = 0; b < 8; b++) begin
      if (w_be[b]) w_new[b*8 +: 8] = w_wshift[b*8 +: 8];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_req   <= '0;
      r_rdata <= 64'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.req_valid) begin
          r_req.write <= bus.req_write;
          r_req.addr  <= bus.req_addr;
          r_req.size  <= bus.req_size;
          r_req.uns   <= bus.req_unsigned;
          r_req.wdata <= bus.req_wdata;
          r_cnt       <= CNT_INIT;
          r_state     <= S_WAIT;
        end
        S_WAIT: if (r_cnt == 4'd0) begin
          r_state <= S_RESP;
          r_err   <= w_err;
          r_rdata <= (r_req.write || w_err) ? 64'd0 : w_load;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
        S_RESP: if (bus.resp_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Reset forces IDLE, so a store aborted in WAIT can never reach the commit edge.
  always_ff @(posedge clock) begin
    if (w_commit) r_mem[w_idx] <= w_new;
  end

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;

`ifdef DMEM_STATS_EN
  logic [31:0] r_loads;
  logic [31:0] r_stores;
  logic [31:0] r_errors;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_loads  <= 32'd0;
      r_stores <= 32'd0;
      r_errors <= 32'd0;
    end else if (w_done) begin
      if (w_err)            r_errors <= r_errors + 32'd1;
      else if (r_req.write) r_stores <= r_stores + 32'd1;
      else                  r_loads  <= r_loads + 32'd1;
    end
  end

  assign stat_loads  = r_loads;
  assign stat_stores = r_stores;
  assign stat_errors = r_errors;
`endif

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the datapath's load/store port, sitting opposite the datapath's memory initiator.
- Accepts one request at a time over a valid/ready handshake and waits a programmable number of cycles.
- Commits stores with byte-lane merging and returns sign- or zero-extended load data over a valid/ready response channel.
- Lets the datapath and its bench exercise multi-cycle, back-pressured memory instead of an ideal combinational array.

Parameters:
- DEPTH_WORDS, 256, number of 64-bit words; byte address range is 0 .. DEPTH_WORDS*8-1.
- LATENCY, 2, cycles from request-accept edge to response-valid edge; legal range 1..15.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  64  byte address.
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = dword.
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
- req_wdata  input  64  store data, right-aligned.
- resp_valid  output  1  response present.
- resp_ready  input  1  initiator accepts response.
- resp_rdata  output  64  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned or out-of-range request.

Behaviour:
- Reset (async):
  - state=IDLE, req_ready=1 after release.
  - resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0.
  - Array contents are not reset.
- States IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - An edge with req_valid=1 captures write, addr, size, unsigned and wdata, loads cnt=LATENCY-1, and moves to WAIT.
- WAIT:
  - req_ready=0.
  - If cnt==0, the edge moves to RESP; otherwise cnt decrements.
  - Result: resp_valid rises exactly LATENCY edges after the accept edge.
- On the WAIT->RESP edge, address checks:
  - err = misaligned OR out-of-range.
  - Misaligned: half with addr[0]!=0; word with addr[1:0]!=0; dword with addr[2:0]!=0.
  - Out-of-range: addr >= DEPTH_WORDS*8.
- On the WAIT->RESP edge, stores with no error:
  - Write byte lanes addr[2:0] .. addr[2:0]+bytes-1 of word addr[63:3], little-endian, from the low bytes of wdata.
  - Other lanes are preserved.
  - resp_rdata=0.
- On the WAIT->RESP edge, loads with no error:
  - Extract the same lanes and right-align them.
  - Extend to 64 bits per req_unsigned; a dword is passed through.
- Error response: no array write, resp_rdata=0, resp_err=1.
- RESP:
  - resp_valid=1.
  - resp_rdata and resp_err are held stable until an edge with resp_ready=1; that edge returns to IDLE with resp_valid=0.
  - req_ready=0 throughout RESP; a request presented during RESP waits.
  - Sustained throughput is one request per LATENCY+2 cycles minimum.
- Reset mid-operation:
  - A store aborted in WAIT is never written.
  - A store already in RESP is already committed.
- Single outstanding request.
- No read-during-write hazard is possible.

Optional Feature:
- DMEM_STATS_EN defined:
  - Adds outputs stat_loads, stat_stores and stat_errors, each 32-bit.
  - Each increments on the WAIT->RESP edge for a successful load, a successful store, or an error respectively.
  - All three clear on reset and wrap at 2^32.
- Undefined: the ports and counters are absent; the remaining behaviour is identical.

Test Plan:
- Store dword 0x0123_4567_89AB_CDEF at 0x10, then load dword at 0x10 -> resp_rdata=0x0123_4567_89AB_CDEF, resp_err=0; resp_valid rises 2 edges after accept (LATENCY=2).
- Store byte 0x80 at 0x15, then load signed byte 0x15 -> 0xFFFF_FFFF_FFFF_FF80; load unsigned -> 0x80; load dword 0x10 -> 0x0123_8067_89AB_CDEF.
- Load half at 0x11 -> resp_err=1, resp_rdata=0; store word at 0x12 -> resp_err=1 and dword 0x10 unchanged.
- Load at 0x800 with DEPTH_WORDS=256 -> resp_err=1; load at 0x7F8 -> resp_err=0.
- Hold resp_ready=0 for 3 cycles in RESP:
  - resp_valid, resp_rdata and resp_err stay stable.
  - req_ready stays 0 with req_valid=1.
  - A new request is accepted only in the cycle after the response handshake.
- Assert reset while a store of 0xFF to 0x20 is in WAIT:
  - resp_valid=0 immediately.
  - A later load of 0x20 returns the prior value.
  - With DMEM_STATS_EN defined, all stats read 0.
